stream_word_serializer: RTL and testbench
=========================================

Name: stream_word_serializer

Overview:
Parametrised width-converting stream serializer for the spectrometer output path. It takes IN_W-bit result words (e.g. accumulated FFT magnitudes) on a ready/valid input and emits them as OUT_W-bit beats on a ready/valid output that can be pinned to the narrow parallel-out pads. It generalises the fixed 16-to-8 LSB-first output. Additions over that version:
- runtime beat order select
- optional per-frame sync beat
- frame-end marker and frame counter

Parameters:
IN_W, 16, input word width; must be an integer multiple of OUT_W, else elaboration error
OUT_W, 8, output beat width
FRAME_LEN, 512, words per frame (FFT size); must be >= 1
SYNC_PAT, 8'hA5, sync beat value, zero-extended or truncated to OUT_W

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
in_data  in  IN_W  input word
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  OUT_W  output beat
out_last  out  1  high on final data beat of a frame
msb_first  in  1  beat order: 0 = least-significant slice first, 1 = most-significant first
sync_en  in  1  insert SYNC_PAT beat before each frame
frame_cnt  out  16  completed frames, wraps at 2^16

Behaviour:
- Definitions:
  - BEATS = IN_W/OUT_W.
  - Internal state: word register, beat index (0..BEATS-1), word index (0..FRAME_LEN-1).
  - "Handshake" means out_valid && out_ready.
- Reset (sync, active-high). At the first rising edge with reset=1:
  - out_valid=0, out_last=0, out_data=0, frame_cnt=0, in_ready=0 while reset is high.
  - State goes to LOAD; beat and word indices go to 0.
  - Any partially sent word or frame is discarded; no further beats of it appear.
- FSM states: LOAD, SYNC, SHIFT.
  - LOAD: in_ready=1, out_valid=0.
    - On input accept: capture in_data, msb_first and sync_en.
    - Go to SYNC if the captured sync_en=1 and word index=0; otherwise go to SHIFT with beat index 0.
  - SYNC: out_valid=1, out_data=SYNC_PAT, out_last=0. On handshake go to SHIFT, beat index 0.
  - SHIFT: out_valid=1; out_data = slice selected by beat index.
    - LSB-first: slice k = bits [k*OUT_W +: OUT_W].
    - MSB-first: slice k = bits [(BEATS-1-k)*OUT_W +: OUT_W].
    - On handshake at beat index < BEATS-1: increment beat index.
    - On handshake at beat index = BEATS-1, the word completes and the word index advances. At FRAME_LEN-1 it wraps to 0 and frame_cnt increments.
- Back-to-back words: in SHIFT, in_ready = (beat index = BEATS-1) && out_ready && (next word is not first of frame with sync_en=1, or sync handled as below).
  - If an input is accepted in that same cycle, load the new word and stay in SHIFT at beat 0, or go to SYNC if the new word starts a frame and sync_en=1.
  - Otherwise go to LOAD.
  - Result: zero-bubble throughput of one beat per cycle while in_valid and out_ready stay high. in_ready has a combinational path from out_ready.
- Latency: word accepted at edge N gives its first beat (or sync beat) with out_valid=1 in cycle N+1.
- out_last = 1 only in SHIFT with beat index = BEATS-1 and word index = FRAME_LEN-1.
- Stability: while out_valid && !out_ready, out_data and out_last are held constant and in_ready=0.
- msb_first and sync_en changes take effect only at word capture. Toggling them mid-word has no effect on that word.
- BEATS=1 (IN_W=OUT_W): pass-through with one-cycle register latency. Sync and last still apply.
- FRAME_LEN=1: every word carries out_last; with sync_en=1, every word is preceded by a sync beat.
- in_valid with reset=1 is ignored.

Test Plan:
- IN_W=16, OUT_W=8, msb_first=0, sync_en=0: send 0x1234, out_ready=1 -> beats 0x34, 0x12; first beat one cycle after accept.
- Same word with msb_first=1 -> beats 0x12, 0x34; flip msb_first after accept -> order unchanged.
- out_ready low for 3 cycles during the 0x34 beat -> out_data stays 0x34 and out_valid stays 1, in_ready=0, no lost or duplicated beats.
- FRAME_LEN=4, sync_en=1, words 1..4 streamed continuously -> output 0xA5, then 01,00,02,00,03,00,04,00.
  - out_last only on the final 00 beat; frame_cnt 0→1.
  - 9 beats in 9 consecutive cycles.
- Continuous stream of 2*FRAME_LEN words (FRAME_LEN=512, sync_en=0) compared against a golden model:
  - 2048 beats with no bubbles.
  - out_last twice; frame_cnt=2.
- Reset asserted after the first beat of word 0x1234:
  - Next cycle out_valid=0, frame_cnt=0.
  - 0x12 is never emitted.
  - A new frame restarts at word index 0, with sync if enabled.

Source files
------------

// File: rtl/stream_word_serializer.sv
// Width-converting ready/valid serializer. It splits IN_W-bit words into OUT_W-bit beats,
// with a selectable beat order, an optional sync beat at the start of each frame, and frame counting.
module stream_word_serializer #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned FRAME_LEN = 512,
    parameter logic [31:0] SYNC_PAT  = 32'h0000_00A5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             msb_first,
    input  logic             sync_en,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned BEATS = IN_W / OUT_W;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0]    LAST_WORD = WW'(FRAME_LEN - 1);
    localparam logic [OUT_W-1:0] SYNC_BEAT = OUT_W'(SYNC_PAT);

    if ((OUT_W == 0) || ((IN_W % OUT_W) != 0)) begin : g_bad_width
        $error("stream_word_serializer: IN_W must be a non-zero multiple of OUT_W");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame
        $error("stream_word_serializer: FRAME_LEN must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t          state_r, next_state_s;
    logic [IN_W-1:0] word_r;
    logic            msb_r;
    logic [BW-1:0]   beat_r, beat_nxt_s, slice_idx_s;
    logic [WW-1:0]   widx_r, widx_nxt_s;
    logic [15:0]     frame_cnt_r, cnt_nxt_s;
    logic [IN_W-1:0] shifted_s;
    logic            capture_s, in_ready_s, out_valid_s, out_last_s;
    logic [OUT_W-1:0] out_data_s;

    // Next-state, index bookkeeping and output decode
    always_comb begin
        next_state_s = state_r;
        beat_nxt_s   = beat_r;
        widx_nxt_s   = widx_r;
        cnt_nxt_s    = frame_cnt_r;
        capture_s    = 1'b0;
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        out_last_s   = 1'b0;
        out_data_s   = '0;
        slice_idx_s  = msb_r ? (LAST_BEAT - beat_r) : beat_r;
        shifted_s    = word_r >> (32'(slice_idx_s) * OUT_W);

        case (state_r)
            ST_LOAD: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    capture_s    = 1'b1;
                    beat_nxt_s   = '0;
                    next_state_s = (sync_en && (widx_r == '0)) ? ST_SYNC : ST_SHIFT;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_SYNC: begin
                out_valid_s = 1'b1;
                out_data_s  = SYNC_BEAT;
                if (out_ready) begin
                    next_state_s = ST_SHIFT;
                    beat_nxt_s   = '0;
                end else begin
                    next_state_s = ST_SYNC;
                end
            end
            ST_SHIFT: begin
                out_valid_s = 1'b1;
                out_data_s  = shifted_s[OUT_W-1:0];
                out_last_s  = (beat_r == LAST_BEAT) && (widx_r == LAST_WORD);
                if (out_ready && (beat_r == LAST_BEAT)) begin
                    // Word completes; a waiting word can be taken in the same cycle.
                    in_ready_s = 1'b1;
                    beat_nxt_s = '0;
                    if (widx_r == LAST_WORD) begin
                        widx_nxt_s = '0;
                        cnt_nxt_s  = frame_cnt_r + 16'd1;
                    end else begin
                        widx_nxt_s = widx_r + WW'(1);
                    end
                    if (in_valid) begin
                        capture_s    = 1'b1;
                        next_state_s = (sync_en && (widx_nxt_s == '0)) ? ST_SYNC : ST_SHIFT;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else if (out_ready) begin
                    beat_nxt_s = beat_r + BW'(1);
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            default: begin
                next_state_s = ST_LOAD;
            end
        endcase
    end

    // State, indices, captured word and frame counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_LOAD;
            beat_r      <= '0;
            widx_r      <= '0;
            word_r      <= '0;
            msb_r       <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r     <= next_state_s;
            beat_r      <= beat_nxt_s;
            widx_r      <= widx_nxt_s;
            frame_cnt_r <= cnt_nxt_s;
            if (capture_s) begin
                word_r <= in_data;
                msb_r  <= msb_first;
            end else begin
                word_r <= word_r;
                msb_r  <= msb_r;
            end
        end
    end

    assign in_ready  = in_ready_s & ~reset;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign out_last  = out_last_s;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_stream_word_serializer.sv
// Bench for stream_word_serializer: directed vectors on a FRAME_LEN=4 instance and a
// queue-based reference model on a FRAME_LEN=512 instance.
module tb_stream_word_serializer;
    localparam int FL_A = 4;
    localparam int FL_B = 512;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_msb_first, a_sync_en;
    logic [15:0] a_in_data, a_frame_cnt;
    logic [7:0]  a_out_data;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_msb_first, b_sync_en;
    logic [15:0] b_in_data, b_frame_cnt;
    logic [7:0]  b_out_data;

    stream_word_serializer #(.IN_W(16), .OUT_W(8), .FRAME_LEN(FL_A)) dut_a (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .msb_first(a_msb_first),
        .sync_en(a_sync_en), .frame_cnt(a_frame_cnt));

    stream_word_serializer #(.IN_W(16), .OUT_W(8), .FRAME_LEN(FL_B)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .msb_first(b_msb_first),
        .sync_en(b_sync_en), .frame_cnt(b_frame_cnt));

    typedef struct {
        logic [15:0] word;
        logic        msb;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        last;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] sync_exp[9];
    int checks = 0;
    int errors = 0;
    int n_acc, n_beats, first_c, last_c;
    logic [8:0] exp_q[$];
    int b_words, b_beats, b_lasts, b_first_cyc, b_last_cyc;
    logic stall_pend;
    logic [8:0] stall_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_slot();
        @(posedge clock);
        #1;
    endtask

    // Reference model for instance b: expected beats are queued at word accept and popped on handshakes.
    task automatic mon_b(input int cyc);
        logic [8:0] e;
        int sh;
        if (stall_pend) begin
            chk("b_stall_valid", b_out_valid, 1'b1);
            chk("b_stall_hold", {b_out_last, b_out_data}, stall_val);
        end
        stall_pend = b_out_valid && !b_out_ready;
        if (stall_pend) begin
            stall_val = {b_out_last, b_out_data};
            chk("b_stall_in_ready", b_in_ready, 1'b0);
        end
        if (b_in_valid && b_in_ready) begin
            if (b_sync_en && ((b_words % FL_B) == 0)) exp_q.push_back({1'b0, 8'hA5});
            for (int k = 0; k < 2; k++) begin
                sh = b_msb_first ? (1 - k) : k;
                e[7:0] = 8'(b_in_data >> (8 * sh));
                e[8] = (k == 1) && ((b_words % FL_B) == (FL_B - 1));
                exp_q.push_back(e);
            end
            b_words++;
        end
        if (b_out_valid && b_out_ready) begin
            if (b_beats == 0) b_first_cyc = cyc;
            b_last_cyc = cyc;
            b_beats++;
            if (b_out_last) b_lasts++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_beat: got %0h but model expected no beat", {b_out_last, b_out_data});
            end else begin
                e = exp_q.pop_front();
                chk("b_beat", {b_out_last, b_out_data}, e);
            end
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 8'h34, 8'h12, 1'b0};
        vecs[1] = '{16'h1234, 1'b1, 8'h12, 8'h34, 1'b0};
        vecs[2] = '{16'hABCD, 1'b0, 8'hCD, 8'hAB, 1'b0};
        vecs[3] = '{16'h00FF, 1'b1, 8'h00, 8'hFF, 1'b1};
        vecs[4] = '{16'hFF00, 1'b0, 8'h00, 8'hFF, 1'b0};
        vecs[5] = '{16'h8001, 1'b1, 8'h80, 8'h01, 1'b0};
        sync_exp = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        stall_pend = 1'b0;
        stall_val = 9'd0;

        reset = 1'b1;
        a_in_valid = 1'b1; a_in_data = 16'hDEAD; a_out_ready = 1'b1; a_msb_first = 1'b0; a_sync_en = 1'b0;
        b_in_valid = 1'b0; b_in_data = 16'h0000; b_out_ready = 1'b1; b_msb_first = 1'b0; b_sync_en = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_last", a_out_last, 1'b0);
        chk("rst_out_data", a_out_data, 8'h00);
        chk("rst_frame_cnt", a_frame_cnt, 16'd0);
        chk("rst_in_ready", a_in_ready, 1'b0);
        drive_slot();
        reset = 1'b0;
        a_in_valid = 1'b0;

        // Table: single words, order flipped right after accept
        for (int i = 0; i < 6; i++) begin
            drive_slot();
            a_in_valid = 1'b1; a_in_data = vecs[i].word; a_msb_first = vecs[i].msb; a_out_ready = 1'b1;
            @(negedge clock);
            chk("a_load_ready", a_in_ready, 1'b1);
            drive_slot();
            a_in_valid = 1'b0; a_msb_first = ~vecs[i].msb;
            @(negedge clock);
            chk("a_beat0_valid", a_out_valid, 1'b1);
            chk("a_beat0_data", a_out_data, vecs[i].b0);
            chk("a_beat0_last", a_out_last, 1'b0);
            chk("a_beat0_in_ready", a_in_ready, 1'b0);
            drive_slot();
            @(negedge clock);
            chk("a_beat1_data", a_out_data, vecs[i].b1);
            chk("a_beat1_last", a_out_last, vecs[i].last);
            chk("a_beat1_in_ready", a_in_ready, 1'b1);
            drive_slot();
            @(negedge clock);
            chk("a_idle", a_out_valid, 1'b0);
        end
        chk("a_frame_cnt_table", a_frame_cnt, 16'd1);

        // Back-pressure on the first beat, then back-to-back second word
        drive_slot();
        a_in_valid = 1'b1; a_in_data = 16'h1234; a_msb_first = 1'b0; a_out_ready = 1'b0;
        @(negedge clock);
        chk("a_stall_accept", a_in_ready, 1'b1);
        drive_slot();
        a_in_data = 16'h5678;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            chk("a_stall_valid", a_out_valid, 1'b1);
            chk("a_stall_data", a_out_data, 8'h34);
            chk("a_stall_in_ready", a_in_ready, 1'b0);
            drive_slot();
        end
        a_out_ready = 1'b1;
        @(negedge clock);
        chk("a_release_data", a_out_data, 8'h34);
        drive_slot();
        @(negedge clock);
        chk("a_b2b_data", a_out_data, 8'h12);
        chk("a_b2b_in_ready", a_in_ready, 1'b1);
        drive_slot();
        a_in_valid = 1'b0;
        @(negedge clock);
        chk("a_b2b_next0", {a_out_valid, a_out_last, a_out_data}, {1'b1, 1'b0, 8'h78});
        drive_slot();
        @(negedge clock);
        chk("a_b2b_next1", {a_out_valid, a_out_last, a_out_data}, {1'b1, 1'b1, 8'h56});
        drive_slot();
        @(negedge clock);
        chk("a_b2b_idle", a_out_valid, 1'b0);
        chk("a_frame_cnt_b2b", a_frame_cnt, 16'd2);

        // Sync frame streamed continuously: 9 beats in 9 cycles
        a_sync_en = 1'b1; n_acc = 0; n_beats = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 20 && n_beats < 9; c++) begin
            drive_slot();
            a_in_valid = (n_acc < 4); a_in_data = 16'(n_acc + 1); a_out_ready = 1'b1;
            @(negedge clock);
            if (a_in_valid && a_in_ready) n_acc++;
            if (a_out_valid) begin
                if (n_beats == 0) first_c = c;
                last_c = c;
                chk("a_sync_data", a_out_data, sync_exp[n_beats]);
                chk("a_sync_last", a_out_last, (n_beats == 8));
                n_beats++;
            end
        end
        chk("a_sync_beats", n_beats, 9);
        chk("a_sync_span", last_c - first_c, 8);
        drive_slot();
        a_in_valid = 1'b0;
        @(negedge clock);
        chk("a_frame_cnt_sync", a_frame_cnt, 16'd3);

        // Reset in the middle of a word
        a_sync_en = 1'b0;
        drive_slot();
        a_in_valid = 1'b1; a_in_data = 16'h0101;
        drive_slot();
        a_in_valid = 1'b0;
        repeat (2) drive_slot();
        a_in_valid = 1'b1; a_in_data = 16'h1234; a_msb_first = 1'b0;
        @(negedge clock);
        chk("a_rst_accept", a_in_ready, 1'b1);
        drive_slot();
        a_in_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        chk("a_rst_first_beat", {a_out_valid, a_out_data}, {1'b1, 8'h34});
        drive_slot();
        a_in_valid = 1'b1; a_in_data = 16'hBEEF; a_sync_en = 1'b1;
        @(negedge clock);
        chk("a_rst_outputs", {a_out_valid, a_out_last, a_out_data}, 10'd0);
        chk("a_rst_frame_cnt", a_frame_cnt, 16'd0);
        chk("a_rst_in_ready", a_in_ready, 1'b0);
        drive_slot();
        reset = 1'b0;
        @(negedge clock);
        chk("a_post_rst_ready", a_in_ready, 1'b1);
        drive_slot();
        a_in_valid = 1'b0;
        @(negedge clock);
        chk("a_post_rst_sync", {a_out_valid, a_out_data}, {1'b1, 8'hA5});
        drive_slot();
        @(negedge clock);
        chk("a_post_rst_b0", a_out_data, 8'hEF);
        drive_slot();
        @(negedge clock);
        chk("a_post_rst_b1", {a_out_last, a_out_data}, {1'b0, 8'hBE});
        drive_slot();
        @(negedge clock);
        chk("a_post_rst_idle", a_out_valid, 1'b0);

        // Continuous stream of two full frames on instance b
        b_words = 0; b_beats = 0; b_lasts = 0; b_first_cyc = 0; b_last_cyc = 0;
        for (int c = 0; c < 2300 && b_beats < 2048; c++) begin
            drive_slot();
            b_in_valid = (b_words < 2 * FL_B); b_out_ready = 1'b1;
            b_in_data = 16'($urandom); b_msb_first = 1'($urandom_range(0, 1));
            @(negedge clock);
            mon_b(c);
        end
        chk("b_stream_beats", b_beats, 2048);
        chk("b_stream_span", b_last_cyc - b_first_cyc, 2047);
        chk("b_stream_lasts", b_lasts, 2);
        drive_slot();
        b_in_valid = 1'b0;
        @(negedge clock);
        chk("b_stream_frame_cnt", b_frame_cnt, 16'd2);
        chk("b_stream_drained", exp_q.size(), 0);

        // Random valid/ready/order/sync against the model
        b_beats = 0;
        for (int c = 0; c < 3000; c++) begin
            drive_slot();
            b_in_valid = ($urandom_range(0, 9) < 7);
            b_out_ready = ($urandom_range(0, 9) < 7);
            b_in_data = 16'($urandom);
            b_msb_first = 1'($urandom_range(0, 1));
            b_sync_en = 1'($urandom_range(0, 1));
            @(negedge clock);
            mon_b(c);
        end
        for (int c = 0; c < 10; c++) begin
            drive_slot();
            b_in_valid = 1'b0; b_out_ready = 1'b1;
            @(negedge clock);
            mon_b(c);
        end
        chk("b_rand_drained", exp_q.size(), 0);
        chk("b_rand_frame_cnt", b_frame_cnt, (b_words / FL_B) % 65536);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
